// File: rtl/deco_exe_pipe_reg_pkg.sv
// Shared types and constants for the decode/execute pipeline boundary.
package deco_exe_pipe_reg_pkg;

    localparam logic [1:0] MEM_TO_REG_MEM  = 2'b00;
    localparam logic [1:0] MEM_TO_REG_ALU  = 2'b01;
    localparam logic [1:0] MEM_TO_REG_TRIG = 2'b11;

    typedef struct packed {
        logic       regWrite;
        logic       memWrite;
        logic [1:0] memToReg;
        logic [3:0] aluControl;
        logic       aluSrc;
        logic       branch;
        logic       flagWrite;
    } deco_exe_cu_signals;

    localparam deco_exe_cu_signals NOP_CTRL = '0;
    localparam int unsigned CTRL_W = $bits(deco_exe_cu_signals);

    // A load is the only producer whose result is not ready for forwarding.
    function automatic logic is_load(input deco_exe_cu_signals c);
        return c.regWrite && (c.memToReg == MEM_TO_REG_MEM);
    endfunction

endpackage

// File: rtl/deco_exe_pipe_reg_hazard.sv
// Combinational load-use hazard detection between the exe slot and decode.
module load_use_hazard_unit
    import deco_exe_pipe_reg_pkg::*;
#(
    parameter int unsigned REG_AW = 4
) (
    input  logic               exe_valid_i,
    input  deco_exe_cu_signals exe_ctrl_i,
    input  logic [REG_AW-1:0]  exe_rd_i,
    input  logic               deco_valid_i,
    input  logic [REG_AW-1:0]  deco_rs1_i,
    input  logic [REG_AW-1:0]  deco_rs2_i,
    input  logic               deco_rs1_used_i,
    input  logic               deco_rs2_used_i,
    output logic               hz_o
);

    logic src_match;

    always_comb begin
        src_match = (deco_rs1_used_i && (deco_rs1_i == exe_rd_i)) ||
                    (deco_rs2_used_i && (deco_rs2_i == exe_rd_i));
        hz_o      = exe_valid_i && is_load(exe_ctrl_i) && deco_valid_i && src_match;
    end

endmodule

// File: rtl/deco_exe_pipe_reg.sv
// Decode-to-execute pipeline register with load-use bubble insertion,
// external stall, branch flush and a saturating bubble counter.
module deco_exe_pipe_reg
    import deco_exe_pipe_reg_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  deco_exe_cu_signals deco_ctrl_i,
    input  logic               deco_valid_i,
    input  logic [REG_AW-1:0]  deco_rs1_i,
    input  logic [REG_AW-1:0]  deco_rs2_i,
    input  logic               deco_rs1_used_i,
    input  logic               deco_rs2_used_i,
    input  logic [REG_AW-1:0]  deco_rd_i,
    input  logic [DATA_W-1:0]  deco_rd1_i,
    input  logic [DATA_W-1:0]  deco_rd2_i,
    input  logic [DATA_W-1:0]  deco_imm_i,
    input  logic [DATA_W-1:0]  deco_pc_i,
    input  logic               ext_stall_i,
    input  logic               flush_i,
    output deco_exe_cu_signals exe_ctrl_o,
    output logic               exe_valid_o,
    output logic [REG_AW-1:0]  exe_rs1_o,
    output logic [REG_AW-1:0]  exe_rs2_o,
    output logic [REG_AW-1:0]  exe_rd_o,
    output logic [DATA_W-1:0]  exe_rd1_o,
    output logic [DATA_W-1:0]  exe_rd2_o,
    output logic [DATA_W-1:0]  exe_imm_o,
    output logic [DATA_W-1:0]  exe_pc_o,
    output logic               hold_o,
    output logic [CNT_W-1:0]   bubble_cnt_o
);

    deco_exe_cu_signals ctrl_d, ctrl_q;
    logic               valid_d, valid_q;
    logic [REG_AW-1:0]  rs1_d, rs1_q, rs2_d, rs2_q, rd_d, rd_q;
    logic [DATA_W-1:0]  rd1_d, rd1_q, rd2_d, rd2_q, imm_d, imm_q, pc_d, pc_q;
    logic [CNT_W-1:0]   cnt_d, cnt_q;
    logic               hz;
    logic               bubble;

    load_use_hazard_unit #(
        .REG_AW (REG_AW)
    ) u_hazard (
        .exe_valid_i     (valid_q),
        .exe_ctrl_i      (ctrl_q),
        .exe_rd_i        (rd_q),
        .deco_valid_i    (deco_valid_i),
        .deco_rs1_i      (deco_rs1_i),
        .deco_rs2_i      (deco_rs2_i),
        .deco_rs1_used_i (deco_rs1_used_i),
        .deco_rs2_used_i (deco_rs2_used_i),
        .hz_o            (hz)
    );

    always_comb begin
        ctrl_d  = ctrl_q;
        valid_d = valid_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        imm_d   = imm_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        bubble  = 1'b0;

        // Flush outranks the stall; a stall alone freezes everything.
        if (flush_i) begin
            bubble = 1'b1;
        end else if (!ext_stall_i) begin
            if (hz) begin
                bubble = 1'b1;
            end else begin
                ctrl_d  = deco_valid_i ? deco_ctrl_i : NOP_CTRL;
                valid_d = deco_valid_i;
                rs1_d   = deco_rs1_i;
                rs2_d   = deco_rs2_i;
                rd_d    = deco_rd_i;
                rd1_d   = deco_rd1_i;
                rd2_d   = deco_rd2_i;
                imm_d   = deco_imm_i;
                pc_d    = deco_pc_i;
            end
        end

        if (bubble) begin
            ctrl_d  = NOP_CTRL;
            valid_d = 1'b0;
            rs1_d   = '0;
            rs2_d   = '0;
            rd_d    = '0;
            rd1_d   = '0;
            rd2_d   = '0;
            imm_d   = '0;
            pc_d    = '0;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q  <= NOP_CTRL;
            valid_q <= 1'b0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        hold_o       = !rst && !flush_i && (ext_stall_i || hz);
        exe_ctrl_o   = ctrl_q;
        exe_valid_o  = valid_q;
        exe_rs1_o    = rs1_q;
        exe_rs2_o    = rs2_q;
        exe_rd_o     = rd_q;
        exe_rd1_o    = rd1_q;
        exe_rd2_o    = rd2_q;
        exe_imm_o    = imm_q;
        exe_pc_o     = pc_q;
        bubble_cnt_o = cnt_q;
    end

endmodule

// File: doc/deco_exe_pipe_reg.md
Name: deco_exe_pipe_reg

Overview:
- Decode-to-execute pipeline register. It captures the control bundle produced by the control-unit decoder (deco_exe_cu_signals), plus operands, immediate, PC and register addresses, and presents them to the execute stage.
- Contains load-use hazard detection. On a hazard it inserts a NOP bubble and freezes fetch/decode.
- Honours an external stall (memory/trig busy) and a branch flush from execute.
- Keeps a saturating bubble counter for performance monitoring.

Parameters:
- DATA_W, 32, width of operand, immediate and PC words
- REG_AW, 4, register-file address width (16 registers)
- CNT_W, 16, width of the bubble counter

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- deco_ctrl_i  in  deco_exe_cu_signals  control bundle from the CU decoder
- deco_valid_i  in  1  decode slot holds a real instruction
- deco_rs1_i  in  REG_AW  source register 1 address
- deco_rs2_i  in  REG_AW  source register 2 address
- deco_rs1_used_i  in  1  instruction reads rs1
- deco_rs2_used_i  in  1  instruction reads rs2
- deco_rd_i  in  REG_AW  destination register
- deco_rd1_i  in  DATA_W  register-file read data 1
- deco_rd2_i  in  DATA_W  register-file read data 2
- deco_imm_i  in  DATA_W  extended immediate
- deco_pc_i  in  DATA_W  PC of the instruction
- ext_stall_i  in  1  downstream busy; hold all state
- flush_i  in  1  taken branch from execute; kill the decode slot
- exe_ctrl_o  out  deco_exe_cu_signals  registered control bundle
- exe_valid_o  out  1  registered valid
- exe_rs1_o, exe_rs2_o, exe_rd_o  out  REG_AW  registered addresses (for forwarding)
- exe_rd1_o, exe_rd2_o, exe_imm_o, exe_pc_o  out  DATA_W  registered data
- hold_o  out  1  combinational; fetch and decode must not advance
- bubble_cnt_o  out  CNT_W  number of bubbles inserted, saturating

Behaviour:
- Reset (async, immediate):
  - exe_ctrl_o = NOP bundle (all fields 0, aluControl 4'b0000, memToReg 2'b00).
  - exe_valid_o = 0; all addresses and data = 0; bubble_cnt_o = 0.
  - hold_o evaluates to 0 while reset is asserted.
- Load-use hazard (combinational, hz):
  - hz = exe_valid_o & exe_ctrl_o.regWrite & (exe_ctrl_o.memToReg == MEM_TO_REG_MEM) & deco_valid_i & ((deco_rs1_used_i & deco_rs1_i == exe_rd_o) | (deco_rs2_used_i & deco_rs2_i == exe_rd_o)).
- Per-edge priority, highest first:
  1. flush_i: load bubble (NOP bundle, valid 0, data and addresses 0); bubble_cnt +1. Flush overrides ext_stall_i and hz.
  2. ext_stall_i: all registers hold, counter holds.
  3. hz: load bubble; bubble_cnt +1.
  4. Otherwise: capture the deco_* inputs. exe_valid_o = deco_valid_i. If deco_valid_i = 0, force the NOP bundle regardless of deco_ctrl_i.
- hold_o = ~flush_i & (ext_stall_i | hz).
- Latency: 1 cycle from decode inputs to exe outputs.
- Hazard duration:
  - A load-use hazard produces exactly one bubble. The next cycle the exe slot holds a NOP, so hz drops and the held decode instruction advances.
  - Back-to-back load to a dependent load also gives one bubble per dependency.
- Counter: saturates at 2^CNT_W-1 and never wraps. Counted events are flush bubbles and hazard bubbles, not external-stall cycles.
- Register 0 is not special; address match is purely numeric.
- Reset asserted mid-stall or mid-bubble: state clears immediately; the first edge after release behaves as the normal-capture case.

Decomposition:
- Add to the stages package:
  - deco_exe_cu_signals (already there)
  - localparam NOP_CTRL (NOP bundle constant)
  - MEM_TO_REG_MEM = 2'b00, MEM_TO_REG_ALU = 2'b01, MEM_TO_REG_TRIG = 2'b11
- One natural sub-module: load_use_hazard_unit (purely combinational hz). The register and counter stay in the top.

Test Plan:
- Reset: rst = 1 mid-run with exe holding an ADD → exe_valid_o = 0, exe_ctrl_o = NOP, bubble_cnt_o = 0 asynchronously, before the next edge.
- Pass-through: ADD with rd = 3, rd1 = 5, rd2 = 7 → next cycle exe_ctrl_o.aluControl = 0010, memToReg = 01, exe_rd1_o = 5, exe_rd2_o = 7, hold_o = 0.
- Load-use: LDR rd = 4, then SUB with rs1 = 4 used → hold_o = 1 for one cycle, exe gets NOP; SUB enters exe the following cycle; bubble_cnt_o = 1. Repeat with rs1_used = 0 → no stall.
- Flush vs stall: ext_stall_i = 1 and flush_i = 1 in the same cycle with a valid MOV → exe becomes NOP, valid 0, hold_o = 0, count +1. ext_stall_i alone for 3 cycles → outputs frozen, count unchanged.
- Invalid decode: deco_valid_i = 0 with deco_ctrl_i.regWrite = 1 → exe_ctrl_o = NOP, exe_valid_o = 0.
- Saturation: with CNT_W = 2, force 5 hazard bubbles → bubble_cnt_o = 3 and stays at 3.
